debounce_scheduler: RTL and testbench

DEBOUNCE_SCHEDULER -- requirements
Module: debounce_scheduler

---
 rtl/debounce_scheduler.sv | 163 ++++++++++++++++
 tb/tb_debounce_scheduler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// debounce_scheduler -- per-channel synchroniser and tick-sampled debouncer
// feeding a round-robin press-event queue with valid/ready handoff. Rev 1.0
// ----------------------------------------------------------------------------
module debounce_scheduler #(
    parameter int N_CH       = 4,
    parameter int TICK_DIV   = 16,
    parameter int STABLE_CNT = 10
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [N_CH-1:0] noisy_i,
    output logic [N_CH-1:0] state_o,
    output logic            evt_valid_o,
    output logic [2:0]      evt_id_o,
    input  logic            evt_ready_i,
    output logic [N_CH-1:0] ovf_o,
    input  logic            clr_ovf_i
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } arb_state_t;

    logic [N_CH-1:0] sync1;
    logic [N_CH-1:0] sync2;
    logic [PW-1:0]   presc;
    logic            tick;
    logic [N_CH-1:0] toggle;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] pending;
    logic [N_CH-1:0] clr_mask;
    logic [N_CH-1:0] ovf_set;
    logic [7:0]      pend_ext;
    logic [2:0]      rr_ptr;
    logic [2:0]      grant;
    logic [3:0]      idx;
    logic            found;
    logic            handshake;
    arb_state_t      arb_state;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= noisy_i;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    assign tick = (presc == PW'(TICK_DIV - 1));

    // Counter reaching STABLE_CNT toggles the level and restarts in one edge.
    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        logic [3:0] cnt;
        logic       differ;

        assign differ     = (sync2[ch] != state_o[ch]);
        assign toggle[ch] = tick & differ & (cnt == 4'(STABLE_CNT - 1));

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt <= '0;
            end else if (tick) begin
                if (!differ || toggle[ch]) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end
        end
    end

    assign rise = toggle & ~state_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_o <= '0;
        end else begin
            state_o <= state_o ^ toggle;
        end
    end

    assign handshake = evt_valid_o & evt_ready_i;
    assign clr_mask  = handshake ? (N_CH'(1) << evt_id_o) : '0;
    // A press that lands on the very edge its pending bit is consumed is not lost.
    assign ovf_set   = rise & pending & ~clr_mask;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending <= '0;
            ovf_o   <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | rise;
            ovf_o   <= (clr_ovf_i ? '0 : ovf_o) | ovf_set;
        end
    end

    assign pend_ext = 8'(pending);

    always_comb begin
        found = 1'b0;
        grant = 3'd0;
        idx   = 4'd0;
        for (int i = 0; i < N_CH; i++) begin
            idx = {1'b0, rr_ptr} + 4'(i);
            if (idx >= 4'(N_CH)) begin
                idx = idx - 4'(N_CH);
            end
            if (!found && pend_ext[idx[2:0]]) begin
                found = 1'b1;
                grant = idx[2:0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            arb_state   <= IDLE;
            evt_valid_o <= 1'b0;
            evt_id_o    <= 3'd0;
            rr_ptr      <= 3'd0;
        end else begin
            case (arb_state)
                IDLE: begin
                    if (found) begin
                        arb_state   <= OFFER;
                        evt_valid_o <= 1'b1;
                        evt_id_o    <= grant;
                    end
                end
                OFFER: begin
                    if (evt_ready_i) begin
                        arb_state   <= IDLE;
                        evt_valid_o <= 1'b0;
                        rr_ptr      <= (evt_id_o == 3'(N_CH - 1)) ? 3'd0 : evt_id_o + 3'd1;
                    end
                end
                default: begin
                    arb_state   <= IDLE;
                    evt_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_debounce_scheduler.sv
`default_nettype none
// tb_debounce_scheduler -- directed checks of debounce, arbitration, overflow
// and reset behaviour with TICK_DIV=4, STABLE_CNT=3, N_CH=4.
module tb_debounce_scheduler;

    logic       clk;
    logic       rst_n;
    logic [3:0] noisy;
    logic [3:0] state;
    logic       evt_valid;
    logic [2:0] evt_id;
    logic       evt_ready;
    logic [3:0] ovf;
    logic       clr_ovf;

    int         n_cmp;
    int         n_bad;
    int         took;
    logic [3:0] seen_state;
    logic       seen_valid;

    debounce_scheduler #(
        .N_CH       (4),
        .TICK_DIV   (4),
        .STABLE_CNT (3)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .noisy_i     (noisy),
        .state_o     (state),
        .evt_valid_o (evt_valid),
        .evt_id_o    (evt_id),
        .evt_ready_i (evt_ready),
        .ovf_o       (ovf),
        .clr_ovf_i   (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            seen_state = seen_state | state;
            seen_valid = seen_valid | evt_valid;
        end
    endtask

    task automatic wait_state(input int ch, input logic val, input int budget);
        took = 0;
        while (state[ch] !== val && took < budget) begin
            @(posedge clk);
            #1;
            took++;
        end
    endtask

    task automatic wait_valid(input int budget);
        took = 0;
        while (evt_valid !== 1'b1 && took < budget) begin
            @(posedge clk);
            #1;
            took++;
        end
    endtask

    task automatic clear_seen();
        seen_state = 4'b0;
        seen_valid = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        noisy     = 4'b0;
        evt_ready = 1'b0;
        clr_ovf   = 1'b0;
        clear_seen();
        step(3);

        check("rst_state", state, 4'b0);
        check("rst_valid", evt_valid, 1'b0);
        check("rst_id", evt_id, 3'd0);
        check("rst_ovf", ovf, 4'b0);
        rst_n = 1'b1;

        // Clean press on channel 1, offered then accepted.
        noisy[1] = 1'b1;
        wait_state(1, 1'b1, 20);
        check("ch1_rise", state, 4'b0010);
        check("ch1_lat", (took <= 15), 1'b1);
        wait_valid(3);
        check("ch1_valid", evt_valid, 1'b1);
        check("ch1_vlat", (took <= 2), 1'b1);
        check("ch1_id", evt_id, 3'd1);
        step(3);
        check("ch1_hold_valid", evt_valid, 1'b1);
        check("ch1_hold_id", evt_id, 3'd1);
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
        check("ch1_hs_valid", evt_valid, 1'b0);
        check("ch1_hs_ovf", ovf, 4'b0);
        noisy[1] = 1'b0;
        clear_seen();
        run(20);
        check("ch1_fall_state", state, 4'b0);
        check("ch1_fall_noevt", seen_valid, 1'b0);

        // Two 2-tick glitches separated by a stable-low gap must both be rejected.
        clear_seen();
        noisy[2] = 1'b1;
        run(8);
        noisy[2] = 1'b0;
        run(8);
        noisy[2] = 1'b1;
        run(8);
        noisy[2] = 1'b0;
        run(16);
        check("glitch_state", seen_state, 4'b0);
        check("glitch_noevt", seen_valid, 1'b0);

        // Reset in the middle of an offer drops it.
        noisy[1] = 1'b1;
        wait_state(1, 1'b1, 20);
        wait_valid(3);
        check("mid_valid", evt_valid, 1'b1);
        rst_n = 1'b0;
        noisy = 4'b0;
        #1;
        check("mid_rst_valid", evt_valid, 1'b0);
        check("mid_rst_state", state, 4'b0);
        step(2);
        rst_n = 1'b1;
        clear_seen();
        run(30);
        check("mid_post_valid", seen_valid, 1'b0);
        check("mid_post_state", seen_state, 4'b0);

        // Simultaneous presses on 0 and 3 with ready held high, twice.
        evt_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            noisy = 4'b1001;
            wait_state(0, 1'b1, 20);
            check("rr_state", state, 4'b1001);
            wait_valid(3);
            check("rr_first_id", evt_id, 3'd0);
            step(1);
            check("rr_gap", evt_valid, 1'b0);
            wait_valid(3);
            check("rr_second_id", evt_id, 3'd3);
            step(1);
            check("rr_done", evt_valid, 1'b0);
            noisy = 4'b0;
            clear_seen();
            run(20);
            check("rr_release_state", state, 4'b0);
            check("rr_release_noevt", seen_valid, 1'b0);
        end
        evt_ready = 1'b0;

        // Press, release, press on channel 2 with consumer stalled.
        noisy[2] = 1'b1;
        wait_state(2, 1'b1, 20);
        wait_valid(3);
        check("ovf_valid", evt_valid, 1'b1);
        check("ovf_id", evt_id, 3'd2);
        noisy[2] = 1'b0;
        wait_state(2, 1'b0, 20);
        check("ovf_released", state, 4'b0);
        noisy[2] = 1'b1;
        wait_state(2, 1'b1, 20);
        check("ovf_flag", ovf, 4'b0100);
        check("ovf_still_valid", evt_valid, 1'b1);
        check("ovf_still_id", evt_id, 3'd2);
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
        check("ovf_hs_valid", evt_valid, 1'b0);
        clear_seen();
        run(6);
        check("ovf_single_evt", seen_valid, 1'b0);
        check("ovf_sticky", ovf, 4'b0100);
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        check("ovf_cleared", ovf, 4'b0);
        noisy[2] = 1'b0;
        run(20);

        // Input held high through reset release yields exactly one event.
        rst_n = 1'b0;
        noisy = 4'b1000;
        step(2);
        rst_n = 1'b1;
        wait_state(3, 1'b1, 20);
        check("hold_state", state, 4'b1000);
        wait_valid(3);
        check("hold_valid", evt_valid, 1'b1);
        check("hold_id", evt_id, 3'd3);
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
        clear_seen();
        run(10);
        check("hold_single_evt", seen_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
